proc_mem_responder: RTL and testbench
=====================================

PROC_MEM_RESPONDER -- requirements
Module: proc_mem_responder

Interface
REQ-001 SHALL have parameter p_mem_nwords, default 256, words of storage; power of two, 4..65536.
REQ-002 SHALL have parameter p_latency, default 0, extra cycles between request accept and response valid; range 0..7.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port reqstream_msg  input  mem_req_4B_t  request: type_, opaque, addr, len, data.
REQ-006 SHALL have port reqstream_val  input  1  request valid.
REQ-007 SHALL have port reqstream_rdy  output  1  responder can accept a request.
REQ-008 SHALL have port respstream_msg  output  mem_resp_4B_t  response: type_, opaque, test, len, data.
REQ-009 SHALL have port respstream_val  output  1  response valid.
REQ-010 SHALL have port respstream_rdy  input  1  consumer accepts response.
REQ-011 SHALL have port num_reqs  output  32  count of accepted requests.

Function
REQ-012 SHALL transfer on a stream only when val and rdy are both high on a rising clk edge.
REQ-013 SHALL use FSM states IDLE, WAIT, RESP.
REQ-014 IDLE: reqstream_rdy=1; on accept, go to WAIT when p_latency>0, else to RESP.
REQ-015 WAIT: reqstream_rdy=0; down-counter loaded with p_latency-1 on accept; go to RESP when counter is 0.
REQ-016 RESP: respstream_val=1; hold msg stable until accepted; on accept return to IDLE.
REQ-017 In RESP with p_latency=0, a response accept and a new request accept SHALL occur in the same cycle (reqstream_rdy=respstream_rdy) for full throughput; next state stays RESP.
REQ-018 Minimum latency: response valid the cycle after request accept (p_latency=0); otherwise accept + 1 + p_latency cycles.
REQ-019 Word index = addr[2 +: log2(p_mem_nwords)]; higher address bits ignored (wrap-around, no error).
REQ-020 READ (type_=0): response data = stored word read at accept time.
REQ-021 WRITE (type_=1): storage updated at the accept edge; response data = 0.
REQ-022 Any other type_: no storage change; response data = 0.
REQ-023 Response type_, opaque, len SHALL echo the request; test = 0.
REQ-024 A read that follows a write to the same word SHALL return the written value.
REQ-025 num_reqs SHALL increment by 1 per accepted request, wrapping 0xFFFFFFFF -> 0.
REQ-026 respstream_msg SHALL come from a register, with no combinational path from reqstream_msg.

Reset
REQ-027 On reset: state IDLE, counter 0, num_reqs 0, respstream_val 0, reqstream_rdy 0 while reset asserted.
REQ-028 Reset mid-WAIT or mid-RESP SHALL discard the pending response; a write already accepted stays committed.
REQ-029 Storage contents SHALL NOT be cleared by reset.

Configuration
REQ-030 Macro PROC_MEM_RESPONDER_SUBWORD_EN SHALL enable sub-word access.
REQ-031 With it defined: len=1 is byte, len=2 is halfword, len=0 is word; writes update only the selected bytes at offset addr[1:0]; reads return the selected bytes right-justified and zero-extended.
REQ-032 Without it: len is ignored for access width (full-word read/write, addr[1:0] ignored) but is still echoed in the response.

Verification
REQ-033 p_latency=0: write addr 0x100 data 0xDEADBEEF opaque 0x05, then read 0x100 -> write resp data 0 opaque 0x05; read resp data 0xDEADBEEF, each valid 1 cycle after accept.
REQ-034 p_latency=3: single read -> respstream_val rises exactly 4 cycles after accept; reqstream_rdy is 0 throughout.
REQ-035 respstream_rdy held low 5 cycles in RESP -> respstream_msg stable, no new request accepted, num_reqs unchanged.
REQ-036 p_mem_nwords=256: write 0x400 = 0x11, read 0x000 -> 0x11 (wrap-around).
REQ-037 Reset asserted mid-WAIT -> respstream_val 0 immediately; num_reqs 0; earlier writes still readable afterward.
REQ-038 SUBWORD_EN: word 0x200 = 0xAABBCCDD, byte write 0x201 = 0x77, read word -> 0xAABB77DD; byte read 0x203 -> 0x000000AA.

Source files
------------

// File: rtl/proc_mem_responder.sv
// proc_mem_responder
//   Single-ported word memory behind a val/rdy request stream and a
//   val/rdy response stream. Each request is answered by exactly one
//   response. The response comes p_latency cycles after the cycle
//   that follows the accept. With p_latency == 0 the responder
//   sustains one request per cycle.
//
//   Optional feature macro: PROC_MEM_RESPONDER_SUBWORD_EN
//     defined   : len selects byte (1), halfword (2) or word (0) access
//                 at byte offset addr[1:0]
//     undefined : every access is a full word, and addr[1:0] is ignored
//
// Ports
//   clk             rising-edge clock
//   reset           asynchronous, active-high reset
//   reqstream_msg   request  {type_, opaque, addr, len, data}
//   reqstream_val   request valid
//   reqstream_rdy   responder can accept a request
//   respstream_msg  response {type_, opaque, test, len, data}, registered
//   respstream_val  response valid
//   respstream_rdy  consumer accepts the response
//   num_reqs        free-running count of accepted requests

package proc_mem_responder_pkg;
  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;

  localparam logic [2:0] MEM_READ  = 3'd0;
  localparam logic [2:0] MEM_WRITE = 3'd1;
endpackage

module proc_mem_responder
  import proc_mem_responder_pkg::*;
#(
  parameter int p_mem_nwords = 256,
  parameter int p_latency    = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  mem_req_4B_t  reqstream_msg,
  input  logic         reqstream_val,
  output logic         reqstream_rdy,
  output mem_resp_4B_t respstream_msg,
  output logic         respstream_val,
  input  logic         respstream_rdy,
  output logic [31:0]  num_reqs
);

  localparam int         AW     = $clog2(p_mem_nwords);
  localparam logic [2:0] LAT_M1 = (p_latency > 0) ? 3'(p_latency - 1) : 3'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t       state;
  logic [2:0]   cnt;
  logic         val_q;
  mem_resp_4B_t resp_q;

  logic [31:0]   mem [p_mem_nwords];
  logic [AW-1:0] idx;
  logic [31:0]   word;
  logic [31:0]   rd_data;
  logic [31:0]   wr_data;
  logic [3:0]    wr_mask;
  logic          req_go;
  logic          resp_go;
  mem_resp_4B_t  next_resp;

  // Address bits above the word index wrap silently, so they are not
  // used anywhere.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{reqstream_msg.addr[31:2+AW], reqstream_msg.addr[1:0]};

  assign idx  = reqstream_msg.addr[2 +: AW];
  assign word = mem[idx];

  // In RESP with zero latency, a new request is taken in the same cycle
  // that the current response drains. This gives back-to-back throughput.
  assign reqstream_rdy = !reset &&
                         ((state == IDLE) ||
                          ((p_latency == 0) && (state == RESP) && respstream_rdy));

  assign req_go         = reqstream_val && reqstream_rdy;
  assign resp_go        = val_q && respstream_rdy;
  assign respstream_val = val_q;
  assign respstream_msg = resp_q;

`ifdef PROC_MEM_RESPONDER_SUBWORD_EN
  logic [1:0]  off;
  logic [2:0]  nbytes;
  logic [31:0] len_mask;

  // The access covers nbytes bytes, starting at byte offset off. Bytes
  // that would fall past the end of the word are dropped.
  always_comb begin
    off      = reqstream_msg.addr[1:0];
    nbytes   = (reqstream_msg.len == 2'd0) ? 3'd4 : {1'b0, reqstream_msg.len};
    wr_mask  = '0;
    len_mask = '0;
    for (int b = 0; b < 4; b++) begin
      if ((b >= int'(off)) && (b < int'(off) + int'(nbytes))) wr_mask[b] = 1'b1;
      if (b < int'(nbytes)) len_mask[8*b +: 8] = 8'hFF;
    end
    wr_data = reqstream_msg.data << {off, 3'b000};
    rd_data = (word >> {off, 3'b000}) & len_mask;
  end
`else
  always_comb begin
    wr_mask = 4'hF;
    wr_data = reqstream_msg.data;
    rd_data = word;
  end
`endif

  // Build the response at accept time. Read data therefore reflects the
  // storage as it was before this edge.
  always_comb begin
    next_resp        = '0;
    next_resp.type_  = reqstream_msg.type_;
    next_resp.opaque = reqstream_msg.opaque;
    next_resp.len    = reqstream_msg.len;
    if (reqstream_msg.type_ == MEM_READ) next_resp.data = rd_data;
  end

  // Storage has no reset. A write that is accepted before a reset
  // stays committed.
  always_ff @(posedge clk) begin
    if (req_go && (reqstream_msg.type_ == MEM_WRITE)) begin
      for (int b = 0; b < 4; b++)
        if (wr_mask[b]) mem[idx][8*b +: 8] <= wr_data[8*b +: 8];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      val_q    <= 1'b0;
      resp_q   <= '0;
      num_reqs <= '0;
    end else begin
      if (req_go) begin
        num_reqs <= num_reqs + 32'd1;
        resp_q   <= next_resp;
      end
      case (state)
        IDLE: begin
          if (req_go) begin
            if (p_latency == 0) begin
              state <= RESP;
              val_q <= 1'b1;
            end else begin
              state <= WAIT;
              cnt   <= LAT_M1;
            end
          end
        end
        WAIT: begin
          if (cnt == 3'd0) begin
            state <= RESP;
            val_q <= 1'b1;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        RESP: begin
          // req_go here implies resp_go. Stay in RESP with the new
          // response already loaded.
          if (resp_go && !req_go) begin
            state <= IDLE;
            val_q <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          val_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_proc_mem_responder.sv
// Testbench for proc_mem_responder. Two instances share one clock:
// dut0 runs with zero latency and dut1 with a latency of 3. A
// behavioural word/byte model predicts every response, and the bench
// checks each prediction with an immediate assertion.

module tb_proc_mem_responder;
  import proc_mem_responder_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst      [2];
  mem_req_4B_t  req_msg  [2];
  logic         req_val  [2];
  logic         req_rdy  [2];
  mem_resp_4B_t resp_msg [2];
  logic         resp_val [2];
  logic         resp_rdy [2];
  logic [31:0]  nreq     [2];

  proc_mem_responder #(.p_mem_nwords(256), .p_latency(0)) dut0 (
    .clk(clk), .reset(rst[0]),
    .reqstream_msg(req_msg[0]), .reqstream_val(req_val[0]), .reqstream_rdy(req_rdy[0]),
    .respstream_msg(resp_msg[0]), .respstream_val(resp_val[0]), .respstream_rdy(resp_rdy[0]),
    .num_reqs(nreq[0]));

  proc_mem_responder #(.p_mem_nwords(256), .p_latency(3)) dut1 (
    .clk(clk), .reset(rst[1]),
    .reqstream_msg(req_msg[1]), .reqstream_val(req_val[1]), .reqstream_rdy(req_rdy[1]),
    .respstream_msg(resp_msg[1]), .respstream_val(resp_val[1]), .respstream_rdy(resp_rdy[1]),
    .num_reqs(nreq[1]));

  int tests = 0;
  int fails = 0;

  // Reference storage, one 256-word image per instance.
  logic [31:0] mref    [2][256];
  logic [31:0] cnt_ref [2];

  function automatic int lat(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Applies one request to the reference image. Returns the expected
  // response data.
  task automatic model(input int d, input mem_req_4B_t m, output logic [31:0] r);
    int n, off, w;
    n   = (m.len == 2'd0) ? 4 : int'(m.len);
    off = int'(m.addr[1:0]);
`ifndef PROC_MEM_RESPONDER_SUBWORD_EN
    n   = 4;
    off = 0;
`endif
    w = int'(m.addr[9:2]);
    r = '0;
    for (int i = 0; i < n; i++) begin
      if (off + i < 4) begin
        if (m.type_ == MEM_READ)
          r[8*i +: 8] = mref[d][w][8*(off+i) +: 8];
        else if (m.type_ == MEM_WRITE)
          mref[d][w][8*(off+i) +: 8] = m.data[8*i +: 8];
      end
    end
  endtask

  // Runs one complete request/response exchange with the consumer
  // always ready.
  task automatic txn(input int d, input logic [2:0] t, input logic [31:0] a,
                     input logic [1:0] ln, input logic [31:0] dat, input logic [7:0] op,
                     output logic [31:0] got);
    mem_req_4B_t  m;
    mem_resp_4B_t er;
    logic [31:0]  ed;
    int           n;
    m = '{type_: t, opaque: op, addr: a, len: ln, data: dat};
    @(negedge clk);
    req_msg[d]  = m;
    req_val[d]  = 1'b1;
    resp_rdy[d] = 1'b1;
    n = 0;
    while (!req_rdy[d] && n < 50) begin @(negedge clk); n++; end
    chk("accept_timeout", 64'(n < 50), 64'd1);
    @(negedge clk);
    req_val[d] = 1'b0;
    model(d, m, ed);
    cnt_ref[d] = cnt_ref[d] + 32'd1;
    n = 0;
    while (!resp_val[d] && n < 20) begin
      if (lat(d) > 0) chk("wait_rdy", 64'(req_rdy[d]), 64'd0);
      @(negedge clk);
      n++;
    end
    chk("latency", 64'(n), 64'(lat(d)));
    er = '{type_: t, opaque: op, test: 2'd0, len: ln, data: ed};
    chk("resp_msg", 64'(resp_msg[d]), 64'(er));
    chk("num_reqs", 64'(nreq[d]), 64'(cnt_ref[d]));
    if (lat(d) > 0) chk("resp_rdy_low", 64'(req_rdy[d]), 64'd0);
    got = resp_msg[d].data;
    @(negedge clk);
    chk("resp_drained", 64'(resp_val[d]), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0]  got, a, hold_n;
    logic [7:0]   pool [8];
    mem_resp_4B_t hold;
    mem_req_4B_t  m;
    logic [31:0]  ed;
    int           r;

    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req_val[d] = 1'b0; resp_rdy[d] = 1'b0;
      req_msg[d] = '0; cnt_ref[d] = '0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_rdy", 64'(req_rdy[d]), 64'd0);
      chk("rst_val", 64'(resp_val[d]), 64'd0);
      chk("rst_cnt", 64'(nreq[d]), 64'd0);
    end
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);
    chk("idle_rdy0", 64'(req_rdy[0]), 64'd1);
    chk("idle_rdy1", 64'(req_rdy[1]), 64'd1);

    // Basic write then read at zero latency.
    txn(0, MEM_WRITE, 32'h100, 2'd0, 32'hDEADBEEF, 8'h05, got);
    chk("wr_data0", 64'(got), 64'd0);
    txn(0, MEM_READ, 32'h100, 2'd0, 32'h0, 8'h06, got);
    chk("rd_beef", 64'(got), 64'hDEADBEEF);

    // Word index wraps above 256 words.
    txn(0, MEM_WRITE, 32'h400, 2'd0, 32'h11, 8'h07, got);
    txn(0, MEM_READ, 32'h000, 2'd0, 32'h0, 8'h08, got);
    chk("wrap", 64'(got), 64'h11);

    // An unknown type leaves storage alone and returns zero.
    txn(0, 3'd5, 32'h100, 2'd0, 32'h12345678, 8'h09, got);
    chk("other_data", 64'(got), 64'd0);
    txn(0, MEM_READ, 32'h100, 2'd0, 32'h0, 8'h0A, got);
    chk("other_nochg", 64'(got), 64'hDEADBEEF);

`ifdef PROC_MEM_RESPONDER_SUBWORD_EN
    txn(0, MEM_WRITE, 32'h200, 2'd0, 32'hAABBCCDD, 8'h10, got);
    txn(0, MEM_WRITE, 32'h201, 2'd1, 32'h77, 8'h11, got);
    txn(0, MEM_READ, 32'h200, 2'd0, 32'h0, 8'h12, got);
    chk("sub_word", 64'(got), 64'hAABB77DD);
    txn(0, MEM_READ, 32'h203, 2'd1, 32'h0, 8'h13, got);
    chk("sub_byte", 64'(got), 64'h000000AA);
`endif

    // Consumer stalls for 5 cycles. A second request waits meanwhile,
    // then both streams transfer in the same cycle.
    @(negedge clk);
    m = '{type_: MEM_READ, opaque: 8'h20, addr: 32'h100, len: 2'd0, data: 32'h0};
    req_msg[0] = m; req_val[0] = 1'b1; resp_rdy[0] = 1'b0;
    chk("stall_idle_rdy", 64'(req_rdy[0]), 64'd1);
    @(negedge clk);
    model(0, m, ed);
    cnt_ref[0] = cnt_ref[0] + 32'd1;
    chk("stall_val", 64'(resp_val[0]), 64'd1);
    hold = resp_msg[0]; hold_n = nreq[0];
    m = '{type_: MEM_WRITE, opaque: 8'h21, addr: 32'h100, len: 2'd0, data: 32'h0BADF00D};
    req_msg[0] = m;
    for (int i = 0; i < 5; i++) begin
      chk("stall_rdy", 64'(req_rdy[0]), 64'd0);
      @(negedge clk);
      chk("stall_msg", 64'(resp_msg[0]), 64'(hold));
      chk("stall_cnt", 64'(nreq[0]), 64'(hold_n));
    end
    chk("stall_data", 64'(hold.data), 64'hDEADBEEF);
    resp_rdy[0] = 1'b1;
    #1;
    chk("thru_rdy", 64'(req_rdy[0]), 64'd1);
    @(negedge clk);
    req_val[0] = 1'b0;
    model(0, m, ed);
    cnt_ref[0] = cnt_ref[0] + 32'd1;
    chk("thru_val", 64'(resp_val[0]), 64'd1);
    chk("thru_op", 64'(resp_msg[0].opaque), 64'h21);
    chk("thru_cnt", 64'(nreq[0]), 64'(cnt_ref[0]));
    @(negedge clk);
    chk("thru_done", 64'(resp_val[0]), 64'd0);
    txn(0, MEM_READ, 32'h100, 2'd0, 32'h0, 8'h22, got);
    chk("thru_wr", 64'(got), 64'h0BADF00D);

    // Latency-3 instance: a directed read, then reset while in WAIT.
    txn(1, MEM_WRITE, 32'h40, 2'd0, 32'hCAFE0001, 8'h30, got);
    txn(1, MEM_READ, 32'h40, 2'd0, 32'h0, 8'h31, got);
    chk("lat3_rd", 64'(got), 64'hCAFE0001);
    @(negedge clk);
    m = '{type_: MEM_WRITE, opaque: 8'h32, addr: 32'h40, len: 2'd0, data: 32'h5A5A1234};
    req_msg[1] = m; req_val[1] = 1'b1; resp_rdy[1] = 1'b1;
    chk("rw_idle_rdy", 64'(req_rdy[1]), 64'd1);
    @(negedge clk);
    req_val[1] = 1'b0;
    model(1, m, ed);
    @(negedge clk);
    rst[1] = 1'b1;
    #1;
    chk("rstw_val", 64'(resp_val[1]), 64'd0);
    chk("rstw_cnt", 64'(nreq[1]), 64'd0);
    chk("rstw_rdy", 64'(req_rdy[1]), 64'd0);
    @(negedge clk);
    rst[1] = 1'b0;
    cnt_ref[1] = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rstw_discard", 64'(resp_val[1]), 64'd0);
    end
    txn(1, MEM_READ, 32'h40, 2'd0, 32'h0, 8'h33, got);
    chk("rstw_commit", 64'(got), 64'h5A5A1234);

    // Random traffic against the model on both instances.
    for (int k = 0; k < 8; k++) pool[k] = 8'(3 + k * 29);
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 8; k++)
        txn(d, MEM_WRITE, {$urandom_range(0, 32'h3FFFFF), pool[k], 2'b00}, 2'd0,
            $urandom, 8'($urandom), got);
      for (int k = 0; k < 30; k++) begin
        a = {22'($urandom), pool[$urandom_range(0, 7)], 2'($urandom)};
        r = $urandom_range(0, 9);
        txn(d, (r < 5) ? MEM_READ : (r < 9) ? MEM_WRITE : 3'($urandom_range(2, 7)),
            a, 2'($urandom), $urandom, 8'($urandom), got);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
